// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - req/gnt/rvalid data-bus bundle between the memory stage and the bus slave
interface mem_stage_if #(
   parameter int BUS_W = 32
);
   logic               mem_req_o;
   logic               mem_we_o;
   logic [BUS_W-1:0]   mem_addr_o;
   logic [BUS_W/8-1:0] mem_be_o;
   logic [BUS_W-1:0]   mem_wdata_o;
   logic               mem_gnt_i;
   logic               mem_rvalid_i;
   logic [BUS_W-1:0]   mem_rdata_i;

   modport master (
      output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
      input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
   );

   modport slave (
      input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
      output mem_gnt_i, mem_rvalid_i, mem_rdata_i
   );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access stage: load/store bus FSM, pipeline stall and MEM/WB register
// Optional misaligned-access trap enabled by MEM_MISALIGN_CHK_EN.
module mem_stage #(
   parameter int BUS_W = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] inst_i,
   input  logic [31:0] op1_add_op2_res_i,
   input  logic [31:0] reg2_rdata_i,
   input  logic [31:0] reg_wdata_i,
   input  logic        reg_we_i,
   input  logic [4:0]  reg_waddr_i,
   mem_stage_if.master bus,
   output logic        stall_o,
   output logic [31:0] reg_wdata_o,
   output logic        reg_we_o,
   output logic [4:0]  reg_waddr_o,
   output logic        misalign_o
);
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_wdata;
   logic        r_we;
   logic [4:0]  r_waddr;
   logic        r_misalign;

   logic [2:0]       w_funct3;
   logic [1:0]       w_a;
   logic             w_byte;
   logic             w_half;
   logic             w_is_load;
   logic             w_is_store;
   logic             w_misalign;
   logic             w_mem_op;
   logic             w_req;
   logic             w_stall;
   logic             w_req_g;
   logic [3:0]       w_be;
   logic [31:0]      w_wdata;
   logic [BUS_W-1:0] w_rdata;
   logic [7:0]       w_lb;
   logic [15:0]      w_lh;
   logic [31:0]      w_load_data;
   logic             w_unused;

   assign w_funct3   = inst_i[14:12];
   assign w_a        = op1_add_op2_res_i[1:0];
   assign w_byte     = (w_funct3[1:0] == 2'b00);
   assign w_half     = (w_funct3[1:0] == 2'b01);
   assign w_is_load  = (inst_i[6:0] == OP_LOAD);
   assign w_is_store = (inst_i[6:0] == OP_STORE);
   assign w_rdata    = bus.mem_rdata_i;
   assign w_unused   = ^{inst_i[31:15], inst_i[11:7]};

`ifdef MEM_MISALIGN_CHK_EN
   assign w_misalign = (w_is_load | w_is_store) &
                       ((w_half & w_a[0]) | (!w_byte & !w_half & (w_a != 2'b00)));
`else
   assign w_misalign = 1'b0;
`endif

   assign w_mem_op = (w_is_load | w_is_store) & !w_misalign;

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = reg2_rdata_i;
      if (w_byte) begin
         w_be    = 4'b0001 << w_a;
         w_wdata = {4{reg2_rdata_i[7:0]}};
      end else if (w_half) begin
         w_be    = 4'b0011 << {w_a[1], 1'b0};
         w_wdata = {2{reg2_rdata_i[15:0]}};
      end
   end

   always_comb begin
      w_lb = w_rdata[7:0];
      case (w_a)
         2'd0:    w_lb = w_rdata[7:0];
         2'd1:    w_lb = w_rdata[15:8];
         2'd2:    w_lb = w_rdata[23:16];
         default: w_lb = w_rdata[31:24];
      endcase
      w_lh = w_a[1] ? w_rdata[31:16] : w_rdata[15:0];
      w_load_data = w_rdata[31:0];
      if (w_byte)
         w_load_data = w_funct3[2] ? {24'd0, w_lb} : {{24{w_lb[7]}}, w_lb};
      else if (w_half)
         w_load_data = w_funct3[2] ? {16'd0, w_lh} : {{16{w_lh[15]}}, w_lh};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Upstream inputs stay frozen while stalled, so they still describe the op in REQ/WAIT/DONE.
   always_comb begin
      w_next  = r_state;
      w_req   = 1'b0;
      w_stall = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_mem_op) begin
               w_req   = 1'b1;
               w_stall = !(w_is_store & bus.mem_gnt_i);
               if (bus.mem_gnt_i) w_next = w_is_load ? S_WAIT : S_IDLE;
               else               w_next = S_REQ;
            end
         end
         S_REQ: begin
            w_req   = 1'b1;
            w_stall = 1'b1;
            if (bus.mem_gnt_i) w_next = w_is_store ? S_DONE : S_WAIT;
         end
         S_WAIT: begin
            w_stall = 1'b1;
            if (bus.mem_rvalid_i) w_next = S_DONE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Gating with rst drops the request the moment reset is asserted, not at the next edge.
   assign w_req_g         = w_req & !rst;
   assign stall_o         = w_stall & !rst;
   assign bus.mem_req_o   = w_req_g;
   assign bus.mem_we_o    = w_req_g & w_is_store;
   assign bus.mem_addr_o  = w_req_g ? {op1_add_op2_res_i[31:2], 2'b00} : 32'd0;
   assign bus.mem_be_o    = w_req_g ? w_be : 4'd0;
   assign bus.mem_wdata_o = w_req_g ? w_wdata : 32'd0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wdata    <= 32'd0;
         r_we       <= 1'b0;
         r_waddr    <= 5'd0;
         r_misalign <= 1'b0;
      end else begin
         r_misalign <= (r_state == S_IDLE) & w_misalign;
         if ((r_state == S_WAIT) && bus.mem_rvalid_i) begin
            r_wdata <= w_load_data;
            r_we    <= reg_we_i;
            r_waddr <= reg_waddr_i;
         end else if ((r_state != S_IDLE) || w_is_load || w_is_store) begin
            r_we    <= 1'b0;
         end else begin
            r_wdata <= reg_wdata_i;
            r_we    <= reg_we_i;
            r_waddr <= reg_waddr_i;
         end
      end
   end

   assign reg_wdata_o = r_wdata;
   assign reg_we_o    = r_we;
   assign reg_waddr_o = r_waddr;
   assign misalign_o  = r_misalign;
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized scoreboard bench for mem_stage with directed corner cases
module tb_mem_stage;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] inst_i, addr_i, sdata_i, alu_i;
   logic        we_i;
   logic [4:0]  waddr_i;
   logic        stall_o, reg_we_o, misalign_o;
   logic [31:0] reg_wdata_o;
   logic [4:0]  reg_waddr_o;

   always #5 clk = ~clk;

   mem_stage_if #(.BUS_W(32)) bus ();

   mem_stage #(.BUS_W(32)) dut (
      .clk(clk), .rst(rst), .inst_i(inst_i), .op1_add_op2_res_i(addr_i),
      .reg2_rdata_i(sdata_i), .reg_wdata_i(alu_i), .reg_we_i(we_i), .reg_waddr_i(waddr_i),
      .bus(bus), .stall_o(stall_o), .reg_wdata_o(reg_wdata_o), .reg_we_o(reg_we_o),
      .reg_waddr_o(reg_waddr_o), .misalign_o(misalign_o)
   );

   typedef struct {
      logic        is_store;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } bus_exp_t;

   bus_exp_t    bus_q[$];
   logic [36:0] wb_q[$];
   int          stall_q[$];
   int          checks = 0;
   int          failures = 0;
   int          stall_run = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic chk_unexpected(input string nm);
      checks++;
      failures++;
      $display("FAIL %s actual=unexpected_event required=none", nm);
   endtask

   // Monitor: pops expectations whenever the DUT presents a bus accept, write-back or end of stall.
   always @(negedge clk) begin
      bus_exp_t    be;
      logic [36:0] wb;
      int          sl;
      if (bus.mem_req_o && bus.mem_gnt_i) begin
         if (bus_q.size() == 0) chk_unexpected("bus_accept");
         else begin
            be = bus_q.pop_front();
            chk("bus_we", bus.mem_we_o, be.is_store);
            chk("bus_addr", bus.mem_addr_o, be.addr);
            if (be.is_store) begin
               chk("bus_be", bus.mem_be_o, be.be);
               chk("bus_wdata", bus.mem_wdata_o, be.wdata);
            end
         end
      end
      if (reg_we_o) begin
         if (wb_q.size() == 0) chk_unexpected("wb_write");
         else begin
            wb = wb_q.pop_front();
            chk("wb_data", {reg_waddr_o, reg_wdata_o}, wb);
         end
      end
      if (stall_o) stall_run++;
      else if (stall_run > 0) begin
         if (stall_q.size() == 0) chk_unexpected("stall_run");
         else begin
            sl = stall_q.pop_front();
            chk("stall_len", stall_run, sl);
         end
         stall_run = 0;
      end
   end

   task automatic set_nop();
      inst_i = NOP; addr_i = 0; sdata_i = 0; alu_i = 0; we_i = 0; waddr_i = 0;
      bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0;
   endtask

   // Reference model: derives bus request, write-back and stall length from the instruction rules.
   task automatic run_one(input logic [31:0] inst, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [31:0] alu, input logic we, input logic [4:0] waddr,
                          input int gd, input int rd, input logic [31:0] rdata);
      logic [6:0]  op;
      logic [2:0]  f3;
      int          sz, a;
      logic [31:0] sh, val;
      bus_exp_t    e;
      op = inst[6:0]; f3 = inst[14:12]; sz = int'(f3[1:0]); a = int'(addr[1:0]);
      inst_i = inst; addr_i = addr; sdata_i = sdata; alu_i = alu; we_i = we; waddr_i = waddr;
      bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0;
      if (op != 7'b0000011 && op != 7'b0100011) begin
         if (we) wb_q.push_back({waddr, alu});
         bus.mem_rvalid_i = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         return;
      end
      e.is_store = (op == 7'b0100011);
      e.addr = addr & ~32'd3;
      if (sz == 0) begin e.be = 4'(1 << a); e.wdata = (sdata & 32'hFF) * 32'h0101_0101; end
      else if (sz == 1) begin e.be = 4'(3 << a); e.wdata = (sdata & 32'hFFFF) * 32'h0001_0001; end
      else begin e.be = 4'hF; e.wdata = sdata; end
      bus_q.push_back(e);
      if (e.is_store) begin
         if (gd > 0) stall_q.push_back(gd + 1);
      end else begin
         stall_q.push_back(gd + rd + 2);
         sh = rdata >> (8 * a);
         if (sz == 0) begin
            val = sh & 32'hFF;
            if (!f3[2] && val >= 128) val = val - 256;
         end else if (sz == 1) begin
            val = sh & 32'hFFFF;
            if (!f3[2] && val >= 32768) val = val - 65536;
         end else val = rdata;
         if (we) wb_q.push_back({waddr, val});
      end
      for (int c = 0; c <= gd; c++) begin
         bus.mem_gnt_i = (c == gd);
         bus.mem_rvalid_i = 1'($urandom_range(0, 1));
         bus.mem_rdata_i = $urandom;
         @(posedge clk); #1;
      end
      bus.mem_gnt_i = 0;
      if (!e.is_store) begin
         for (int c = 0; c <= rd; c++) begin
            bus.mem_rvalid_i = (c == rd);
            bus.mem_rdata_i = (c == rd) ? rdata : $urandom;
            @(posedge clk); #1;
         end
         bus.mem_rvalid_i = 0;
      end
      if (!e.is_store || gd > 0) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0]  pt_ops[4];
      logic [2:0]  ld_f3[5];
      logic [31:0] inst, addr;
      int          k, sz;
      pt_ops = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b1101111};
      ld_f3  = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

      rst = 1;
      set_nop();
      bus.mem_rdata_i = 0;
      inst_i = 32'h0000_2003; addr_i = 32'h100;
      bus.mem_gnt_i = 1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", bus.mem_req_o, 0);
      chk("rst_we", bus.mem_we_o, 0);
      chk("rst_be", bus.mem_be_o, 0);
      chk("rst_addr", bus.mem_addr_o, 0);
      chk("rst_wdata", bus.mem_wdata_o, 0);
      chk("rst_stall", stall_o, 0);
      chk("rst_wb", {reg_we_o, reg_waddr_o, reg_wdata_o}, 0);
      chk("rst_misalign", misalign_o, 0);
      set_nop();
      #1 rst = 0;
      @(posedge clk); #1;

      run_one(32'h0000_02B3, 0, 0, 32'h1234, 1, 5, 0, 0, 0);
      run_one(32'h0000_2023, 32'h100, 32'hDEAD_BEEF, 0, 1, 0, 0, 0, 0);
      run_one(32'h0000_0003, 32'h103, 0, 0, 1, 6, 2, 0, 32'h80FF_FF00);
      run_one(32'h0000_4003, 32'h103, 0, 0, 1, 6, 2, 0, 32'h80FF_FF00);
      run_one(32'h0000_1023, 32'h202, 32'h0000_ABCD, 0, 0, 0, 1, 0, 0);
      run_one(32'h0000_1003, 32'h002, 0, 0, 1, 0, 0, 1, 32'h8001_1234);

      // Reset while a load waits for rvalid: its data must never reach write-back.
      inst_i = 32'h0000_0003; addr_i = 32'h100; we_i = 1; waddr_i = 7;
      bus.mem_gnt_i = 1;
      bus_q.push_back('{1'b0, 32'h100, 4'h1, 32'h0});
      stall_q.push_back(1);
      @(posedge clk); #1;
      bus.mem_gnt_i = 0;
      rst = 1;
      #1;
      chk("rstwait_req", bus.mem_req_o, 0);
      chk("rstwait_stall", stall_o, 0);
      set_nop();
      @(posedge clk); #1;
      rst = 0;
      @(posedge clk); #1;
      bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h5555_AAAA;
      @(posedge clk); #1;
      bus.mem_rvalid_i = 0;
      @(posedge clk); #1;
      chk("rstwait_no_wb", reg_we_o, 0);

`ifdef MEM_MISALIGN_CHK_EN
      inst_i = 32'h0000_2003; addr_i = 32'h101; we_i = 1; waddr_i = 9;
      @(negedge clk);
      chk("mis_req", bus.mem_req_o, 0);
      chk("mis_stall", stall_o, 0);
      @(posedge clk); #1;
      chk("mis_flag", misalign_o, 1);
      chk("mis_we", reg_we_o, 0);
      set_nop();
      @(posedge clk); #1;
      chk("mis_pulse_end", misalign_o, 0);
`endif

      for (int n = 0; n < 300; n++) begin
         inst = $urandom;
         addr = $urandom;
         k = $urandom_range(0, 2);
         if (k == 0) inst[6:0] = pt_ops[$urandom_range(0, 3)];
         else begin
            inst[6:0] = (k == 1) ? 7'b0000011 : 7'b0100011;
            inst[14:12] = (k == 1) ? ld_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
            sz = int'(inst[13:12]);
            if (sz == 1) addr[0] = 1'b0;
            if (sz == 2) addr[1:0] = 2'b00;
         end
         run_one(inst, addr, $urandom, $urandom, 1'($urandom_range(0, 1)), 5'($urandom),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      end

      set_nop();
      repeat (3) @(posedge clk);
      #1;
      chk("bus_q_drained", bus_q.size(), 0);
      chk("wb_q_drained", wb_q.size(), 0);
      chk("stall_q_drained", stall_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
